ham_secded_dec: RTL and testbench

- Parametrised SECDED (single-error-correct, double-error-detect) Hamming decoder.
- Successor to the fixed 12-bit/8-bit single-error decoder.
- Sits on the read path of the dual-port RAM, between the memory's code output and the consumer.
- Decoder is 2-stage pipelined with a valid/ready handshake, error classification and saturating error counters.

---
 rtl/ham_secded_dec.sv | 166 ++++++++++++++++
 tb/tb_ham_secded_dec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ham_secded_dec.sv
// rtl/ham_secded_dec.sv - 2-stage pipelined parametrised SECDED Hamming decoder with error counters
// Optional error-position output enabled by HAM_SECDED_DEC_ERR_POS_EN.
module ham_secded_dec #(
   parameter int DATA_W = 8,
   parameter int P_W    = 4,
   parameter int CNT_W  = 16,
   localparam int N      = DATA_W + P_W,
   localparam int CODE_W = N + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [CODE_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_ce,
   output logic              o_ue,
`ifdef HAM_SECDED_DEC_ERR_POS_EN
   output logic [P_W-1:0]    o_err_pos,
`endif
   input  logic              i_cnt_clr,
   output logic [CNT_W-1:0]  o_ce_cnt,
   output logic [CNT_W-1:0]  o_ue_cnt
);

   generate
      if ((2 ** P_W) < (N + 1)) begin : g_bad_p_w
         $error("ham_secded_dec: P_W too small for DATA_W");
      end
   endgenerate

   localparam logic [P_W-1:0] N_P = P_W'(N);

   // Data bits occupy the non-power-of-two Hamming positions in ascending order.
   function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
      logic [DATA_W-1:0] d;
      logic [CODE_W-1:0] t;
      int k;
      d = '0;
      k = 0;
      for (int i = 1; i <= N; i++) begin
         if ((i & (i - 1)) != 0) begin
            t = c >> i;
            d = d | (DATA_W'(t[0]) << k);
            k++;
         end
      end
      return d;
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [CODE_W-1:0] s1_code_q, s1_code_d;
   logic [P_W-1:0]    s1_syn_q, s1_syn_d;
   logic              s1_par_q, s1_par_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ce_q, ce_d;
   logic              ue_q, ue_d;
   logic [P_W-1:0]    pos_q, pos_d;
   logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
   logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;

   logic              s2_adv;
   logic              in_xfer;
   logic              out_xfer;
   logic [CODE_W-1:0] scan;
   logic [CODE_W-1:0] fixed;
   logic              corr_en;

   always_comb begin
      s2_adv   = !s2_valid_q || i_ready;
      o_ready  = !s1_valid_q || s2_adv;
      in_xfer  = i_valid && o_ready;
      out_xfer = s2_valid_q && i_ready;
   end

   always_comb begin
      s1_syn_d = '0;
      scan     = '0;
      for (int i = 1; i <= N; i++) begin
         scan = i_data >> i;
         if (scan[0]) s1_syn_d = s1_syn_d ^ P_W'(i);
      end
      s1_par_d   = ^i_data;
      s1_code_d  = in_xfer ? i_data : s1_code_q;
      s1_valid_d = o_ready ? i_valid : s1_valid_q;
      if (!in_xfer) begin
         s1_syn_d = s1_syn_q;
         s1_par_d = s1_par_q;
      end
   end

   // Syndromes beyond N cannot be a single error and fall through to ue.
   always_comb begin
      corr_en = s1_par_q && (s1_syn_q != '0) && (s1_syn_q <= N_P);
      fixed   = s1_code_q;
      if (corr_en) fixed = s1_code_q ^ (CODE_W'(1) << s1_syn_q);
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      data_d     = data_q;
      ce_d       = ce_q;
      ue_d       = ue_q;
      pos_d      = pos_q;
      if (s2_adv && s1_valid_q) begin
         data_d = extract(fixed);
         ce_d   = s1_par_q && (s1_syn_q <= N_P);
         ue_d   = (s1_par_q && (s1_syn_q > N_P)) || (!s1_par_q && (s1_syn_q != '0));
         pos_d  = (s1_par_q && (s1_syn_q <= N_P)) ? s1_syn_q : '0;
      end
   end

   always_comb begin
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      if (i_cnt_clr) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else begin
         if (out_xfer && ce_q && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + 1'b1;
         if (out_xfer && ue_q && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s1_code_q  <= '0;
         s1_syn_q   <= '0;
         s1_par_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         data_q     <= '0;
         ce_q       <= 1'b0;
         ue_q       <= 1'b0;
         pos_q      <= '0;
         ce_cnt_q   <= '0;
         ue_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_code_q  <= s1_code_d;
         s1_syn_q   <= s1_syn_d;
         s1_par_q   <= s1_par_d;
         s2_valid_q <= s2_valid_d;
         data_q     <= data_d;
         ce_q       <= ce_d;
         ue_q       <= ue_d;
         pos_q      <= pos_d;
         ce_cnt_q   <= ce_cnt_d;
         ue_cnt_q   <= ue_cnt_d;
      end
   end

   assign o_valid  = s2_valid_q;
   assign o_data   = data_q;
   assign o_ce     = ce_q;
   assign o_ue     = ue_q;
   assign o_ce_cnt = ce_cnt_q;
   assign o_ue_cnt = ue_cnt_q;
`ifdef HAM_SECDED_DEC_ERR_POS_EN
   assign o_err_pos = pos_q;
`else
   logic unused_pos;
   assign unused_pos = ^pos_q;
`endif

endmodule

// File: tb/tb_ham_secded_dec.sv
// tb/tb_ham_secded_dec.sv - directed self-checking bench for ham_secded_dec (default parameters)
// Checks o_err_pos as well when HAM_SECDED_DEC_ERR_POS_EN is defined.
module tb_ham_secded_dec;

   logic        clk;
   logic        rst;
   logic [12:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_ce;
   logic        o_ue;
   logic        i_cnt_clr;
   logic [15:0] o_ce_cnt;
   logic [15:0] o_ue_cnt;
`ifdef HAM_SECDED_DEC_ERR_POS_EN
   logic [3:0]  o_err_pos;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   ham_secded_dec dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_ce      (o_ce),
      .o_ue      (o_ue),
`ifdef HAM_SECDED_DEC_ERR_POS_EN
      .o_err_pos (o_err_pos),
`endif
      .i_cnt_clr (i_cnt_clr),
      .o_ce_cnt  (o_ce_cnt),
      .o_ue_cnt  (o_ue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One word through an idle pipeline with i_ready=1; checks latency and flags.
   task automatic run_word(input string tag, input logic [12:0] code, input logic [7:0] ed,
                           input logic ece, input logic eue, input logic [3:0] epos);
      int n;
      i_data  = code;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, 1);
      chk({tag, "_data"}, o_data, ed);
      chk({tag, "_ce"}, o_ce, ece);
      chk({tag, "_ue"}, o_ue, eue);
`ifdef HAM_SECDED_DEC_ERR_POS_EN
      chk({tag, "_pos"}, o_err_pos, epos);
`else
      if (epos > 4'd12) $display("unexpected position argument in %s", tag);
`endif
      @(posedge clk); #1;
   endtask

   logic [12:0] bp_code [5];
   logic [7:0]  bp_data [5];

   initial begin
      int k, m, cyc, seen;
      logic [7:0] prev_data;
      logic       prev_stall;

      bp_code[0] = 13'h000F; bp_data[0] = 8'h01;
      bp_code[1] = 13'h0033; bp_data[1] = 8'h02;
      bp_code[2] = 13'h0055; bp_data[2] = 8'h04;
      bp_code[3] = 13'h0096; bp_data[3] = 8'h08;
      bp_code[4] = 13'h0303; bp_data[4] = 8'h10;

      // Reset with junk presented on the input.
      rst = 1'b1; i_data = 13'h1E6E; i_valid = 1'b1; i_ready = 1'b1; i_cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; i_valid = 1'b0;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_ce", o_ce, 0);
      chk("rst_ue", o_ue, 0);
      chk("rst_cecnt", o_ce_cnt, 0);
      chk("rst_uecnt", o_ue_cnt, 0);
      chk("rst_ready", o_ready, 1);
      @(posedge clk); #1;
      chk("rst_junk_dropped", o_valid, 0);

      run_word("clean0", 13'h0000, 8'h00, 0, 0, 0);
      run_word("cleanFF", 13'h1EEE, 8'hFF, 0, 0, 0);
      run_word("bit7", 13'h1E6E, 8'hFF, 1, 0, 7);
      chk("cecnt1", o_ce_cnt, 1);
      run_word("bit3", 13'h0008, 8'h00, 1, 0, 3);
      run_word("bit0", 13'h0001, 8'h00, 1, 0, 0);
      chk("cecnt3", o_ce_cnt, 3);
      chk("uecnt0", o_ue_cnt, 0);
      run_word("dbl", 13'h0028, 8'h03, 0, 1, 0);
      chk("uecnt1", o_ue_cnt, 1);
      run_word("s15", 13'h1006, 8'h80, 0, 1, 0);
      chk("uecnt2", o_ue_cnt, 2);
      chk("cecnt3b", o_ce_cnt, 3);

      // Backpressure: i_ready low for the first 4 cycles while 5 words are offered.
      k = 0; m = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
      while (m < 5 && cyc < 40) begin
         i_ready = (cyc >= 4);
         i_valid = (k < 5);
         i_data  = bp_code[(k < 5) ? k : 0];
         #1;
         if (cyc == 3) begin
            chk("bp_ready_low", o_ready, 0);
            chk("bp_accepted2", k, 2);
         end
         if (prev_stall && o_valid) chk("bp_hold", o_data, prev_data);
         if (o_valid && i_ready) begin
            chk("bp_order", o_data, bp_data[m]);
            m++;
         end
         if (i_valid && o_ready) k++;
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      chk("bp_out5", m, 5);
      chk("bp_in5", k, 5);
      #1;
      chk("bp_no_dup", o_valid, 0);
      @(posedge clk); #1;

      // Clear, then saturate the ce counter.
      i_cnt_clr = 1'b1;
      @(posedge clk); #1;
      i_cnt_clr = 1'b0;
      chk("clr_ce", o_ce_cnt, 0);
      chk("clr_ue", o_ue_cnt, 0);
      i_data = 13'h0001; i_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_ce", o_ce_cnt, 16'hFFFF);
      chk("sat_ue", o_ue_cnt, 0);

      // Clear coincident with a ce output transfer.
      i_data = 13'h0001; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      chk("cc_valid", o_valid, 1);
      chk("cc_ce", o_ce, 1);
      i_cnt_clr = 1'b1;
      @(posedge clk); #1;
      i_cnt_clr = 1'b0;
      chk("cc_cnt", o_ce_cnt, 0);
      chk("cc_gone", o_valid, 0);

      // Reset with a full, stalled pipeline.
      run_word("pre_rst", 13'h0028, 8'h03, 0, 1, 0);
      chk("pre_rst_ue", o_ue_cnt, 1);
      i_ready = 1'b0; i_data = 13'h0008; i_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_full", o_ready, 0);
      chk("mid_valid", o_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_ce", o_ce, 0);
      chk("mid_rst_cecnt", o_ce_cnt, 0);
      chk("mid_rst_uecnt", o_ue_cnt, 0);
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (o_valid) seen++;
      end
      chk("mid_rst_discard", seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
